// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared constants and FSM encoding for the UART program loader
package prog_loader_pkg;
    localparam int IMEM_DEPTH = 256;
    localparam int BYTE_W = 8;
    localparam int WORD_W = 32;
    localparam int ADDR_W = $clog2(IMEM_DEPTH);
    localparam logic [BYTE_W-1:0] SYNC_DEFAULT = 8'hA5;
    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DATA, S_CHECK} state_t;
endpackage

// File: rtl/prog_uart_rx.sv
// prog_uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and framing-error detect
module prog_uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              byte_valid,
    output logic [BYTE_W-1:0] byte_data,
    output logic              frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t st;
    logic [2:0] sync;
    logic [CW-1:0] cnt;
    logic [2:0] bit_idx;
    logic [BYTE_W-1:0] shreg;
    logic rx;
    assign rx = sync[1];
    // sync[2] is the previous synchronized sample, used for falling-edge start detection
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= 3'b111;
            st <= R_IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shreg <= '0;
            byte_valid <= 1'b0;
            byte_data <= '0;
            frame_err <= 1'b0;
        end else begin
            sync <= {sync[1:0], uart_rx};
            byte_valid <= 1'b0;
            frame_err <= 1'b0;
            case (st)
                R_IDLE: begin
                    cnt <= '0;
                    if (sync[2] && !rx) st <= R_START;
                end
                R_START: begin
                    cnt <= cnt == HALF ? '0 : cnt + CW'(1);
                    bit_idx <= '0;
                    if (cnt == HALF) st <= rx ? R_IDLE : R_DATA;
                end
                R_DATA: begin
                    cnt <= cnt == FULL ? '0 : cnt + CW'(1);
                    if (cnt == FULL) begin
                        shreg <= {rx, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) st <= R_STOP;
                    end
                end
                R_STOP: begin
                    cnt <= cnt == FULL ? '0 : cnt + CW'(1);
                    if (cnt == FULL) begin
                        st <= R_IDLE;
                        byte_valid <= rx;
                        frame_err <= !rx;
                        byte_data <= rx ? shreg : byte_data;
                    end
                end
            endcase
        end
    end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses UART load packets and writes 32-bit words into instruction memory
module uart_prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter logic [BYTE_W-1:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_error,
    output logic [ADDR_W:0]   words_loaded
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic byte_valid, frame_err;
    logic [BYTE_W-1:0] byte_data;
    state_t state;
    logic [ADDR_W:0] count;
    logic [1:0] byte_idx;
    logic [WORD_W-BYTE_W-1:0] word_buf;
    logic [BYTE_W-1:0] csum;
    logic [TW-1:0] tmo;
    logic abort;
    logic [ADDR_W:0] next_words;

    prog_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .reset     (reset),
        .uart_rx   (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign abort = state != S_IDLE && (frame_err || (!byte_valid && tmo == TW'(TIMEOUT_CYCLES - 1)));
    assign next_words = words_loaded + (ADDR_W+1)'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            count <= '0;
            byte_idx <= '0;
            word_buf <= '0;
            csum <= '0;
            tmo <= '0;
            mem_we <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            cpu_hold <= 1'b0;
            load_done <= 1'b0;
            load_error <= 1'b0;
            words_loaded <= '0;
        end else begin
            mem_we <= 1'b0;
            load_done <= 1'b0;
            tmo <= (state == S_IDLE || byte_valid) ? '0 : tmo + TW'(1);
            if (abort) begin
                state <= S_IDLE;
                load_error <= 1'b1;
            end else if (byte_valid) begin
                case (state)
                    S_IDLE: if (byte_data == SYNC_BYTE) begin
                        state <= S_COUNT;
                        cpu_hold <= 1'b1;
                        load_error <= 1'b0;
                        words_loaded <= '0;
                        csum <= '0;
                        byte_idx <= '0;
                    end
                    S_COUNT: begin
                        count <= {byte_data == '0, byte_data};
                        state <= S_DATA;
                    end
                    S_DATA: begin
                        csum <= csum ^ byte_data;
                        byte_idx <= byte_idx + 2'd1;
                        word_buf <= {byte_data, word_buf[WORD_W-BYTE_W-1:BYTE_W]};
                        if (byte_idx == 2'd3) begin
                            mem_we <= 1'b1;
                            mem_addr <= words_loaded[ADDR_W-1:0];
                            mem_wdata <= {byte_data, word_buf};
                            words_loaded <= next_words;
                            if (next_words == count) state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        state <= S_IDLE;
                        load_done <= byte_data == csum;
                        cpu_hold <= byte_data != csum;
                        load_error <= byte_data != csum;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: randomized packet stimulus checked against a packet-level reference model
module tb_uart_prog_loader;
    localparam int CPB = 4;
    localparam int TMO = 1000;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic uart_rx = 1'b1;
    logic mem_we, cpu_hold, load_done, load_error;
    logic [7:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0] words_loaded;
    int n_tests = 0;
    int n_fail = 0;
    int done_cnt = 0;
    logic [31:0] words [256];
    logic [39:0] wq [$];

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_rx     (uart_rx),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .cpu_hold    (cpu_hold),
        .load_done   (load_done),
        .load_error  (load_error),
        .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (load_done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop);
        uart_rx = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(CPB);
        end
        uart_rx = stop;
        tick(CPB);
        uart_rx = 1'b1;
        tick(CPB);
    endtask

    function automatic logic [7:0] calc_cs(input int nw);
        logic [7:0] x = 8'h00;
        for (int w = 0; w < nw; w++) x = x ^ words[w][7:0] ^ words[w][15:8] ^ words[w][23:16] ^ words[w][31:24];
        return x;
    endfunction

    task automatic send_load(input int nw, input logic [7:0] cs);
        send_byte(8'hA5, 1'b1);
        send_byte(8'(nw), 1'b1);
        chk("hold_active", 64'(cpu_hold), 64'd1);
        for (int w = 0; w < nw; w++)
            for (int k = 0; k < 4; k++) send_byte(words[w][8*k +: 8], 1'b1);
        send_byte(cs, 1'b1);
    endtask

    task automatic verify(input string tag, input int nw, input bit ok, input int wb, input int db);
        tick(4);
        chk({tag, "_nwrites"}, 64'(wq.size() - wb), 64'(nw));
        for (int i = 0; i < nw; i++)
            if (wb + i < wq.size()) chk({tag, "_write"}, 64'(wq[wb + i]), 64'({8'(i), words[i]}));
        chk({tag, "_words_loaded"}, 64'(words_loaded), 64'(nw));
        chk({tag, "_load_error"}, 64'(load_error), 64'(!ok));
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'(!ok));
        chk({tag, "_load_done"}, 64'(done_cnt - db), 64'(ok));
    endtask

    initial begin
        int wb, db, nw;
        logic [7:0] cs;
        tick(3);
        chk("reset_outputs", 64'({mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error, words_loaded}), 64'd0);
        reset = 1'b0;
        tick(5);

        words[0] = 32'h00000013;
        words[1] = 32'h005000B3;
        wb = wq.size(); db = done_cnt;
        send_load(2, calc_cs(2));
        verify("basic", 2, 1'b1, wb, db);

        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h12, 1'b1);
        tick(4);
        chk("junk_hold", 64'(cpu_hold), 64'd0);
        words[0] = $urandom;
        wb = wq.size(); db = done_cnt;
        send_load(1, calc_cs(1));
        verify("junk", 1, 1'b1, wb, db);

        words[0] = 32'h00000013;
        words[1] = 32'h005000B3;
        wb = wq.size(); db = done_cnt;
        send_load(2, 8'h00);
        verify("badcs", 2, 1'b0, wb, db);

        wb = wq.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        tick(TMO + 200);
        chk("tmo_nwrites", 64'(wq.size() - wb), 64'd0);
        chk("tmo_load_error", 64'(load_error), 64'd1);
        chk("tmo_cpu_hold", 64'(cpu_hold), 64'd1);
        words[0] = $urandom;
        wb = wq.size(); db = done_cnt;
        send_load(1, calc_cs(1));
        verify("after_tmo", 1, 1'b1, wb, db);

        for (int r = 0; r < 4; r++) begin
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) words[w] = $urandom;
            words[0][15:8] = 8'hA5;
            cs = calc_cs(nw);
            if ($urandom_range(0, 1) == 1) cs = cs ^ 8'($urandom_range(1, 255));
            wb = wq.size(); db = done_cnt;
            send_load(nw, cs);
            verify("rand", nw, cs == calc_cs(nw), wb, db);
        end

        for (int w = 0; w < 256; w++) words[w] = 32'(w);
        wb = wq.size(); db = done_cnt;
        send_load(256, calc_cs(256));
        verify("full", 256, 1'b1, wb, db);

        for (int w = 0; w < 5; w++) words[w] = 32'h11223344 + 32'(w);
        wb = wq.size();
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        for (int w = 0; w < 3; w++)
            for (int k = 0; k < 4; k++) send_byte(words[w][8*k +: 8], 1'b1);
        tick(4);
        chk("pre_reset_nwrites", 64'(wq.size() - wb), 64'd3);
        reset = 1'b1;
        tick(2);
        chk("midload_reset", 64'({mem_we, mem_addr, mem_wdata, cpu_hold, load_done, load_error, words_loaded}), 64'd0);
        reset = 1'b0;
        tick(10);
        wb = wq.size();
        for (int w = 3; w < 5; w++)
            for (int k = 0; k < 4; k++) send_byte(words[w][8*k +: 8], 1'b1);
        tick(4);
        chk("post_reset_nwrites", 64'(wq.size() - wb), 64'd0);
        chk("post_reset_hold", 64'(cpu_hold), 64'd0);
        db = done_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h37, 1'b0);
        tick(4);
        chk("ferr_load_error", 64'(load_error), 64'd1);
        chk("ferr_cpu_hold", 64'(cpu_hold), 64'd1);
        chk("ferr_done", 64'(done_cnt - db), 64'd0);
        words[0] = $urandom;
        wb = wq.size(); db = done_cnt;
        send_load(1, calc_cs(1));
        verify("after_ferr", 1, 1'b1, wb, db);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
